// File: rtl/mcpu_mem_il1c_pkg.sv
// Shared types and constants for the set-associative instruction L1 cache.
package mcpu_mem_il1c_pkg;

    localparam int LINE_BITS   = 256;
    localparam int OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_FILL
    } il1c_state_e;

    // Physical page number plus the virtual index bits above the set field.
    function automatic int tag_width(input int set_width);
        return 32 - OFFSET_BITS - set_width;
    endfunction

endpackage

// File: rtl/mcpu_mem_il1c_way.sv
// One cache way: data and tag RAMs sharing a set index.
module mcpu_mem_il1c_way
    import mcpu_mem_il1c_pkg::*;
#(
    parameter int SET_WIDTH = 4,
    parameter int TAG_WIDTH = 23
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [SET_WIDTH-1:0] set,
    input  logic [TAG_WIDTH-1:0] wtag,
    input  logic [LINE_BITS-1:0] wline,
    output logic [TAG_WIDTH-1:0] rtag,
    output logic [LINE_BITS-1:0] rline
);

    sp_bram #(
        .WIDTH      (LINE_BITS),
        .ADDR_WIDTH (SET_WIDTH)
    ) u_data (
        .clk   (clk),
        .we    (we),
        .addr  (set),
        .wdata (wline),
        .rdata (rline)
    );

    sp_bram #(
        .WIDTH      (TAG_WIDTH),
        .ADDR_WIDTH (SET_WIDTH)
    ) u_tag (
        .clk   (clk),
        .we    (we),
        .addr  (set),
        .wdata (wtag),
        .rdata (rtag)
    );

endmodule

// File: rtl/sp_bram.sv
// Single-port block RAM with synchronous read (read-before-write).
module sp_bram #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [1 << ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mcpu_mem_il1c_sa.sv
// N-way VIPT instruction L1 cache with round-robin replacement.
// Define MCPU_MEM_IL1C_PERF_EN to add saturating hit/miss counters.
module mcpu_mem_il1c_sa
    import mcpu_mem_il1c_pkg::*;
#(
    parameter int NUM_WAYS  = 2,
    parameter int SET_WIDTH = 4
) (
    input  logic          clkrst_mem_clk,
    input  logic          clkrst_mem_rst,
    input  logic [31:4]   il1c_addr,
    input  logic          il1c_re,
    input  logic          il1c_inval,
    output logic          il1c_ready,
    output logic          il1c_pvalid,
    output logic [127:0]  il1c_packet,
    output logic          il1c_fault,
    output logic [31:12]  il1c2tlb_addr,
    output logic          il1c2tlb_re,
    input  logic [3:0]    il1c2tlb_flags,
    input  logic [31:12]  il1c2tlb_phys_addr,
    input  logic          il1c2tlb_ready,
    output logic          il1c2arb_valid,
    output logic [2:0]    il1c2arb_opcode,
    output logic [31:5]   il1c2arb_addr,
    input  logic [255:0]  il1c2arb_rdata,
    input  logic          il1c2arb_rvalid,
`ifdef MCPU_MEM_IL1C_PERF_EN
    output logic [31:0]   il1c_hit_count,
    output logic [31:0]   il1c_miss_count,
`endif
    input  logic          il1c2arb_stall
);

    localparam int TAG_W = tag_width(SET_WIDTH);
    localparam int SETS  = 1 << SET_WIDTH;
    localparam int VIC_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    if (SET_WIDTH < 1 || SET_WIDTH > 7) begin : g_bad_set_width
        $error("mcpu_mem_il1c_sa: SET_WIDTH must be 1..7 to stay inside the page offset");
    end
    if (NUM_WAYS != 1 && NUM_WAYS != 2 && NUM_WAYS != 4) begin : g_bad_num_ways
        $error("mcpu_mem_il1c_sa: NUM_WAYS must be 1, 2 or 4");
    end

    il1c_state_e          state;
    logic                 lk;
    logic [31:4]          lat_addr;
    logic [31:5]          fill_addr;
    logic                 fill_kill;
    logic [LINE_BITS-1:0] line_buf;
    logic [NUM_WAYS-1:0]  valid  [SETS];
    logic [VIC_W-1:0]     victim [SETS];

    logic                 accept, lookup, fault, hit, miss, hit_any, fill_now;
    logic [SET_WIDTH-1:0] rd_set, lat_set;
    logic [TAG_W-1:0]     cmp_tag, fill_tag;
    logic [TAG_W-1:0]     rd_tag  [NUM_WAYS];
    logic [LINE_BITS-1:0] rd_line [NUM_WAYS];
    logic [LINE_BITS-1:0] hit_line, out_line;
    logic [NUM_WAYS-1:0]  hit_vec, way_we;
    logic [VIC_W-1:0]     next_victim;
    logic                 unused_ok;

    assign unused_ok = &{1'b0, il1c2tlb_flags[3:2]};

    assign lat_set  = lat_addr[OFFSET_BITS +: SET_WIDTH];
    assign accept   = il1c_re && il1c_ready;
    // RAMs are re-read every cycle so their output tracks the pending lookup.
    assign rd_set   = accept ? il1c_addr[OFFSET_BITS +: SET_WIDTH] : lat_set;
    assign cmp_tag  = TAG_W'({il1c2tlb_phys_addr, lat_addr[11:5]} >> SET_WIDTH);
    assign fill_tag = TAG_W'(fill_addr >> SET_WIDTH);
    assign fill_now = (state == ST_WAIT) && il1c2arb_rvalid;
    assign next_victim = (NUM_WAYS > 1) ? victim[lat_set] + VIC_W'(1) : '0;

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        assign way_we[w]  = fill_now && (victim[lat_set] == VIC_W'(w));
        assign hit_vec[w] = valid[lat_set][w] && (rd_tag[w] == cmp_tag);

        mcpu_mem_il1c_way #(
            .SET_WIDTH (SET_WIDTH),
            .TAG_WIDTH (TAG_W)
        ) u_way (
            .clk   (clkrst_mem_clk),
            .we    (way_we[w]),
            .set   (rd_set),
            .wtag  (fill_tag),
            .wline (il1c2arb_rdata),
            .rtag  (rd_tag[w]),
            .rline (rd_line[w])
        );
    end

    // Lowest-indexed hitting way wins.
    always_comb begin
        hit_line = '0;
        hit_any  = 1'b0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (hit_vec[w] && !hit_any) begin
                hit_line = rd_line[w];
                hit_any  = 1'b1;
            end
        end
    end

    assign lookup = (state == ST_IDLE) && lk && il1c2tlb_ready;
    assign fault  = lookup && !(il1c2tlb_flags[0] && il1c2tlb_flags[1]);
    assign hit    = lookup && !fault && hit_any;
    assign miss   = lookup && !fault && !hit_any;

    assign il1c_ready  = ((state == ST_IDLE) && (!lk || (il1c2tlb_ready && !miss)))
                       || (state == ST_FILL);
    assign il1c_pvalid = hit || (state == ST_FILL);
    assign il1c_fault  = fault;
    assign out_line    = (state == ST_FILL) ? line_buf : hit_line;
    assign il1c_packet = lat_addr[4] ? out_line[LINE_BITS-1:LINE_BITS/2]
                                     : out_line[LINE_BITS/2-1:0];

    assign il1c2tlb_re     = accept;
    assign il1c2tlb_addr   = accept ? il1c_addr[31:12] : lat_addr[31:12];
    assign il1c2arb_valid  = (state == ST_REQ);
    assign il1c2arb_opcode = '0;
    assign il1c2arb_addr   = fill_addr;

    always_ff @(posedge clkrst_mem_clk or posedge clkrst_mem_rst) begin
        if (clkrst_mem_rst) begin
            state     <= ST_IDLE;
            lk        <= 1'b0;
            lat_addr  <= '0;
            fill_addr <= '0;
            fill_kill <= 1'b0;
            line_buf  <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                valid[s]  <= '0;
                victim[s] <= '0;
            end
        end else begin
            if (accept) begin
                lk       <= 1'b1;
                lat_addr <= il1c_addr;
            end else if (lookup) begin
                lk <= 1'b0;
            end

            // Invalidate beats a same-cycle fill; an earlier one kills the fill via fill_kill.
            if (il1c_inval) begin
                for (int unsigned s = 0; s < SETS; s++) begin
                    valid[s] <= '0;
                end
            end else if (fill_now && !fill_kill) begin
                valid[lat_set] <= valid[lat_set] | way_we;
            end

            case (state)
                ST_IDLE: begin
                    if (miss) begin
                        state     <= ST_REQ;
                        fill_addr <= {il1c2tlb_phys_addr, lat_addr[11:5]};
                        fill_kill <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (il1c_inval) fill_kill <= 1'b1;
                    if (!il1c2arb_stall) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (il1c_inval) fill_kill <= 1'b1;
                    if (il1c2arb_rvalid) begin
                        line_buf        <= il1c2arb_rdata;
                        victim[lat_set] <= next_victim;
                        state           <= ST_FILL;
                    end
                end
                ST_FILL: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MCPU_MEM_IL1C_PERF_EN
    always_ff @(posedge clkrst_mem_clk or posedge clkrst_mem_rst) begin
        if (clkrst_mem_rst) begin
            il1c_hit_count  <= '0;
            il1c_miss_count <= '0;
        end else begin
            if (hit && il1c_hit_count != '1) il1c_hit_count <= il1c_hit_count + 32'd1;
            if (miss && il1c_miss_count != '1) il1c_miss_count <= il1c_miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mcpu_mem_il1c_sa.sv
// Directed self-checking bench for mcpu_mem_il1c_sa (2 ways, 16 sets).
module tb_mcpu_mem_il1c_sa;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:4]   il1c_addr;
    logic          re, inval;
    logic          ready, pvalid, fault;
    logic [127:0]  packet;
    logic [31:12]  tlb_addr;
    logic          tlb_re;
    logic [3:0]    tlb_flags;
    logic [31:12]  tlb_phys;
    logic          tlb_ready;
    logic          arb_valid;
    logic [2:0]    arb_opcode;
    logic [31:5]   arb_addr;
    logic [255:0]  rdata;
    logic          rvalid, stall;
`ifdef MCPU_MEM_IL1C_PERF_EN
    logic [31:0]   hit_count, miss_count;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [255:0] pat_a, pat_b, pat_c, pat_d;

    always #5 clk = ~clk;

    mcpu_mem_il1c_sa #(
        .NUM_WAYS  (2),
        .SET_WIDTH (4)
    ) dut (
        .clkrst_mem_clk     (clk),
        .clkrst_mem_rst     (rst),
        .il1c_addr          (il1c_addr),
        .il1c_re            (re),
        .il1c_inval         (inval),
        .il1c_ready         (ready),
        .il1c_pvalid        (pvalid),
        .il1c_packet        (packet),
        .il1c_fault         (fault),
        .il1c2tlb_addr      (tlb_addr),
        .il1c2tlb_re        (tlb_re),
        .il1c2tlb_flags     (tlb_flags),
        .il1c2tlb_phys_addr (tlb_phys),
        .il1c2tlb_ready     (tlb_ready),
        .il1c2arb_valid     (arb_valid),
        .il1c2arb_opcode    (arb_opcode),
        .il1c2arb_addr      (arb_addr),
        .il1c2arb_rdata     (rdata),
        .il1c2arb_rvalid    (rvalid),
`ifdef MCPU_MEM_IL1C_PERF_EN
        .il1c_hit_count     (hit_count),
        .il1c_miss_count    (miss_count),
`endif
        .il1c2arb_stall     (stall)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Miss on a, optional REQ stall and invalidate in WAIT, then refill with line.
    task automatic fill(input logic [31:0] a, input logic [255:0] line,
                        input int unsigned stall_n, input logic inval_w);
        logic [127:0] exp_pkt;
        exp_pkt   = a[4] ? line[255:128] : line[127:0];
        tlb_phys  = a[31:12];
        il1c_addr = a[31:4];
        re        = 1'b1;
        stall     = (stall_n != 0);
        @(negedge clk);
        chk($sformatf("acc_ready_%0h", a), ready, 1);
        chk($sformatf("acc_tlb_re_%0h", a), tlb_re, 1);
        chk($sformatf("acc_tlb_addr_%0h", a), tlb_addr, a[31:12]);
        step;
        re = 1'b0;
        @(negedge clk);
        chk($sformatf("miss_ready_%0h", a), ready, 0);
        chk($sformatf("miss_pvalid_%0h", a), pvalid, 0);
        step;
        for (int unsigned i = 0; i < stall_n; i++) begin
            @(negedge clk);
            chk($sformatf("stall_valid_%0d", i), arb_valid, 1);
            chk($sformatf("stall_addr_%0d", i), arb_addr, a[31:5]);
            chk($sformatf("stall_ready_%0d", i), ready, 0);
            step;
        end
        stall = 1'b0;
        @(negedge clk);
        chk($sformatf("req_valid_%0h", a), arb_valid, 1);
        chk($sformatf("req_addr_%0h", a), arb_addr, a[31:5]);
        chk($sformatf("req_opcode_%0h", a), arb_opcode, 0);
        step;
        if (inval_w) begin
            inval = 1'b1;
            @(negedge clk);
            chk("inval_wait_ready", ready, 0);
            step;
            inval = 1'b0;
        end
        rvalid = 1'b1;
        rdata  = line;
        @(negedge clk);
        chk($sformatf("wait_arb_%0h", a), arb_valid, 0);
        chk($sformatf("wait_pvalid_%0h", a), pvalid, 0);
        step;
        rvalid = 1'b0;
        @(negedge clk);
        chk($sformatf("fill_pvalid_%0h", a), pvalid, 1);
        chk($sformatf("fill_packet_%0h", a), packet, exp_pkt);
        chk($sformatf("fill_ready_%0h", a), ready, 1);
        step;
    endtask

    task automatic hit(input logic [31:0] a, input logic [127:0] exp_pkt);
        tlb_phys  = a[31:12];
        il1c_addr = a[31:4];
        re        = 1'b1;
        @(negedge clk);
        chk($sformatf("hit_accept_%0h", a), ready, 1);
        step;
        re = 1'b0;
        @(negedge clk);
        chk($sformatf("hit_pvalid_%0h", a), pvalid, 1);
        chk($sformatf("hit_packet_%0h", a), packet, exp_pkt);
        step;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pat_a = {128'hA1A1_0000_1111_2222_3333_4444_5555_6666, 128'hA0A0_7777_8888_9999_AAAA_BBBB_CCCC_DDDD};
        pat_b = {128'hB1B1_0101_0202_0303_0404_0505_0606_0707, 128'hB0B0_1010_2020_3030_4040_5050_6060_7070};
        pat_c = {128'hC1C1_DEAD_BEEF_0000_1234_5678_9ABC_DEF0, 128'hC0C0_FEED_FACE_1111_8765_4321_0FED_CBA9};
        pat_d = {128'hD1D1_5A5A_A5A5_0F0F_F0F0_3C3C_C3C3_9999, 128'hD0D0_1357_2468_ACE0_BDF1_0000_FFFF_7E7E};

        rst = 1'b1; re = 1'b0; il1c_addr = '0; inval = 1'b0;
        tlb_flags = 4'b0011; tlb_phys = '0; tlb_ready = 1'b1;
        rdata = '0; rvalid = 1'b0; stall = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_pvalid", pvalid, 0);
        chk("rst_fault", fault, 0);
        chk("rst_arb_valid", arb_valid, 0);
        chk("rst_tlb_re", tlb_re, 0);
`ifdef MCPU_MEM_IL1C_PERF_EN
        chk("rst_hit_count", hit_count, 0);
        chk("rst_miss_count", miss_count, 0);
`endif
        step;
        rst = 1'b0;

        // Cold miss then hits on both halves of the line.
        fill(32'h0000_1000, pat_a, 0, 1'b0);
        hit(32'h0000_1000, pat_a[127:0]);
        hit(32'h0000_1010, pat_a[255:128]);

        // Back-to-back hits: one packet per cycle.
        tlb_phys = 20'h00001; il1c_addr = 28'h000_0100; re = 1'b1;
        step;
        il1c_addr = 28'h000_0101;
        @(negedge clk);
        chk("b2b_pvalid0", pvalid, 1);
        chk("b2b_packet0", packet, pat_a[127:0]);
        chk("b2b_ready0", ready, 1);
        step;
        re = 1'b0;
        @(negedge clk);
        chk("b2b_pvalid1", pvalid, 1);
        chk("b2b_packet1", packet, pat_a[255:128]);
        step;

        // Set 0 replacement: 0x2000 (with 5-cycle stall) then 0x3000 evicts way 0.
        fill(32'h0000_2000, pat_b, 5, 1'b0);
        fill(32'h0000_3000, pat_c, 0, 1'b0);
        hit(32'h0000_2000, pat_b[127:0]);
        fill(32'h0000_1000, pat_a, 0, 1'b0);
        hit(32'h0000_3000, pat_c[127:0]);

        // One cycle of TLB delay pushes the packet out one cycle.
        tlb_ready = 1'b0; tlb_phys = 20'h00003; il1c_addr = 28'h000_0301; re = 1'b1;
        step;
        re = 1'b0;
        @(negedge clk);
        chk("tlbd_pvalid_early", pvalid, 0);
        chk("tlbd_ready_wait", ready, 0);
        step;
        tlb_ready = 1'b1;
        @(negedge clk);
        chk("tlbd_pvalid", pvalid, 1);
        chk("tlbd_packet", packet, pat_c[255:128]);
        step;

        // Execute and present faults.
        for (int unsigned f = 0; f < 2; f++) begin
            tlb_flags = (f == 0) ? 4'b0001 : 4'b0010;
            tlb_phys = 20'h00003; il1c_addr = 28'h000_0300; re = 1'b1;
            step;
            re = 1'b0;
            @(negedge clk);
            chk($sformatf("fault_pulse_%0d", f), fault, 1);
            chk($sformatf("fault_pvalid_%0d", f), pvalid, 0);
            chk($sformatf("fault_arb_%0d", f), arb_valid, 0);
            step;
            @(negedge clk);
            chk($sformatf("fault_end_%0d", f), fault, 0);
            chk($sformatf("fault_arb_after_%0d", f), arb_valid, 0);
            step;
        end
        tlb_flags = 4'b0011;

        // Invalidate during WAIT: packet returned, line left invalid.
        fill(32'h0000_4020, pat_d, 0, 1'b1);
        fill(32'h0000_4020, pat_d, 0, 1'b0);
        hit(32'h0000_4020, pat_d[127:0]);

        // Reset in REQ drops the arbiter request asynchronously.
        tlb_phys = 20'h00005; il1c_addr = 28'h000_5040; re = 1'b1; stall = 1'b1;
        step;
        re = 1'b0;
        step;
        @(negedge clk);
        chk("rreq_valid", arb_valid, 1);
        #1 rst = 1'b1;
        #1 chk("rreq_async_drop", arb_valid, 0);
        step;
        rst = 1'b0; stall = 1'b0;

        // Reset in WAIT, late rvalid ignored, previously valid line misses.
        fill(32'h0000_1000, pat_a, 0, 1'b0);
        hit(32'h0000_1000, pat_a[127:0]);
        tlb_phys = 20'h00005; il1c_addr = 28'h000_5040; re = 1'b1;
        step;
        re = 1'b0;
        step;
        step;
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        rvalid = 1'b1; rdata = pat_b;
        @(negedge clk);
        chk("rwait_pvalid0", pvalid, 0);
        chk("rwait_ready", ready, 1);
        step;
        rvalid = 1'b0;
        @(negedge clk);
        chk("rwait_pvalid1", pvalid, 0);
        step;
        fill(32'h0000_1000, pat_a, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
